imem_boot_regfile: RTL and testbench

//  Parametrised instruction-memory register file for the i281 CPU; successor to the fixed 16x16 IMEM banks.

---
 rtl/imem_boot_regfile.sv | 193 +++++++++++++++++++
 tb/tb_imem_boot_regfile.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_regfile.sv
// ---------------------------------------------------------------------------
// imem_boot_regfile
//   Instruction-memory register file for the i281 CPU. After reset it copies a
//   boot image, one word per cycle, from an external code source. When the copy
//   is done it becomes a memory with one write port and one read port.
//   A RELOAD request in RUN re-runs the copy. Writes attempted during the copy
//   are dropped and reported by WRITE_REJECT.
//
// Parameters
//   DATA_W   word width in bits
//   ADDR_W   address width; DEPTH = 2**ADDR_W words
//   OUT_REG  0: combinational read, 1: registered read (one-cycle latency)
//
// Ports
//   CLOCK         single clock, rising edge
//   RESET         asynchronous, active-low reset
//   READ_SELECT   read address
//   READ_DATA     read data
//   WRITE_ENABLE  write request, honoured only when READY=1
//   WRITE_SELECT  write address
//   IMEM_INPUT    write data
//   RELOAD        request to re-run the boot copy (ignored while booting)
//   BOOT_ADDR     address presented to the boot image source
//   BOOT_DATA     image word for BOOT_ADDR, valid in the same cycle
//   READY         1 = boot complete, writes accepted
//   WRITE_REJECT  registered pulse: a write was dropped in the previous cycle
// ---------------------------------------------------------------------------
module imem_boot_regfile #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 4,
    parameter int OUT_REG = 0
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic [ADDR_W-1:0] READ_SELECT,
    output logic [DATA_W-1:0] READ_DATA,
    input  logic              WRITE_ENABLE,
    input  logic [ADDR_W-1:0] WRITE_SELECT,
    input  logic [DATA_W-1:0] IMEM_INPUT,
    input  logic              RELOAD,
    output logic [ADDR_W-1:0] BOOT_ADDR,
    input  logic [DATA_W-1:0] BOOT_DATA,
    output logic              READY,
    output logic              WRITE_REJECT
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic              reject_q, reject_d;

    // Single internal write port shared by the boot copy and the user path.
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples the pre-edge values, independent of block ordering.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_q <= ST_BOOT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    // NOTE: every combinational output gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_BOOT: begin
                // Counter wraps to 0 naturally after the last word.
                cnt_d = cnt_q + 1'b1;
                if (&cnt_q) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (RELOAD) begin
                    state_d = ST_BOOT;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_BOOT;
                cnt_d   = '0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Output logic
    // -----------------------------------------------------------------------
    always_comb begin
        wr_en     = 1'b0;
        wr_addr   = cnt_q;
        wr_data   = BOOT_DATA;
        reject_d  = 1'b0;
        READY     = 1'b0;
        BOOT_ADDR = cnt_q;
        unique case (state_q)
            ST_BOOT: begin
                wr_en    = 1'b1;
                reject_d = WRITE_ENABLE;
            end
            ST_RUN: begin
                READY   = 1'b1;
                wr_en   = WRITE_ENABLE;
                wr_addr = WRITE_SELECT;
                wr_data = IMEM_INPUT;
            end
            default: begin
                wr_en = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Storage
    // -----------------------------------------------------------------------
    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    // NOTE: the array is reset because the contents must read as zero straight
    // after reset; that keeps it in flops rather than a RAM macro.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            reject_q <= 1'b0;
        end else begin
            reject_q <= reject_d;
        end
    end

    assign WRITE_REJECT = reject_q;

    // -----------------------------------------------------------------------
    // Read path: neither variant bypasses a same-cycle write.
    // -----------------------------------------------------------------------
    generate
        if (OUT_REG != 0) begin : g_rd_reg
            logic [DATA_W-1:0] rd_q, rd_d;

            always_comb begin
                rd_d = mem_q[READ_SELECT];
            end

            always_ff @(posedge CLOCK or negedge RESET) begin
                if (!RESET) begin
                    rd_q <= '0;
                end else begin
                    rd_q <= rd_d;
                end
            end

            assign READ_DATA = rd_q;
        end else begin : g_rd_comb
            assign READ_DATA = mem_q[READ_SELECT];
        end
    endgenerate

endmodule

// File: tb/tb_imem_boot_regfile.sv
// ---------------------------------------------------------------------------
// tb_imem_boot_regfile
//   Drives a combinational-read and a registered-read instance with the same
//   stimulus. Each has its own boot source that looks up a bench-side image.
//   A behavioural model tracks memory contents, READY, the boot position and
//   the reject pulse.
// ---------------------------------------------------------------------------
module tb_imem_boot_regfile;

    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] rd_sel;
    logic          we;
    logic [AW-1:0] wr_sel;
    logic [DW-1:0] wr_data;
    logic          reload;

    logic [DW-1:0] rd0, rd1;
    logic [AW-1:0] boot_addr0, boot_addr1;
    logic [DW-1:0] boot_data0, boot_data1;
    logic          ready0, ready1;
    logic          rej0, rej1;

    logic [DW-1:0] image [DEPTH];

    // Reference model state
    logic [DW-1:0] m_mem [DEPTH];
    bit            m_ready;
    int            m_cnt;
    bit            m_rej;
    logic [DW-1:0] m_rd1;

    int checks   = 0;
    int failures = 0;

    assign boot_data0 = image[boot_addr0];
    assign boot_data1 = image[boot_addr1];

    imem_boot_regfile #(.DATA_W(DW), .ADDR_W(AW), .OUT_REG(0)) u_comb (
        .CLOCK(clk), .RESET(rst_n), .READ_SELECT(rd_sel), .READ_DATA(rd0),
        .WRITE_ENABLE(we), .WRITE_SELECT(wr_sel), .IMEM_INPUT(wr_data),
        .RELOAD(reload), .BOOT_ADDR(boot_addr0), .BOOT_DATA(boot_data0),
        .READY(ready0), .WRITE_REJECT(rej0)
    );

    imem_boot_regfile #(.DATA_W(DW), .ADDR_W(AW), .OUT_REG(1)) u_reg (
        .CLOCK(clk), .RESET(rst_n), .READ_SELECT(rd_sel), .READ_DATA(rd1),
        .WRITE_ENABLE(we), .WRITE_SELECT(wr_sel), .IMEM_INPUT(wr_data),
        .RELOAD(reload), .BOOT_ADDR(boot_addr1), .BOOT_DATA(boot_data1),
        .READY(ready1), .WRITE_REJECT(rej1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        m_ready = 1'b0;
        m_cnt   = 0;
        m_rej   = 1'b0;
        m_rd1   = '0;
    endtask

    // Advance the model by one clock using the current inputs, then step the
    // DUTs to 1 time unit after the rising edge.
    task automatic tick();
        m_rd1 = m_mem[rd_sel];
        if (!m_ready) begin
            m_mem[m_cnt] = image[m_cnt];
            m_rej        = we;
            m_cnt        = m_cnt + 1;
            if (m_cnt == DEPTH) begin
                m_ready = 1'b1;
                m_cnt   = 0;
            end
        end else begin
            m_rej = 1'b0;
            if (we) m_mem[wr_sel] = wr_data;
            if (reload) begin
                m_ready = 1'b0;
                m_cnt   = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        we      = 1'b0;
        wr_sel  = '0;
        wr_data = '0;
        reload  = 1'b0;
    endtask

    task automatic test_reset();
        for (int k = 0; k < DEPTH; k++) image[k] = 16'hA000 + 16'(k);
        idle_inputs();
        rd_sel = 4'd3;
        rst_n  = 1'b0;
        model_reset();
        @(negedge clk);
        checks++;
        if (ready0 !== 1'b0 || ready1 !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready: got %b/%b expected 0", ready0, ready1);
        end
        checks++;
        if (rd0 !== 16'h0000 || rd1 !== 16'h0000) begin
            failures++;
            $display("FAIL reset_read: got %h/%h expected 0000", rd0, rd1);
        end
        checks++;
        if (rej0 !== 1'b0 || boot_addr0 !== 4'd0 || boot_addr1 !== 4'd0) begin
            failures++;
            $display("FAIL reset_boot: rej=%b addr=%h/%h expected 0/0/0", rej0, boot_addr0, boot_addr1);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_boot();
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (ready0 !== 1'b0 || boot_addr0 !== 4'(i)) begin
                failures++;
                $display("FAIL boot_step%0d: ready=%b addr=%h expected 0/%h", i, ready0, boot_addr0, 4'(i));
            end
            tick();
        end
        checks++;
        if (ready0 !== 1'b1 || ready1 !== 1'b1) begin
            failures++;
            $display("FAIL boot_ready_16: got %b/%b expected 1", ready0, ready1);
        end
        for (int a = 0; a < DEPTH; a++) begin
            rd_sel = 4'(a);
            #1;
            checks++;
            if (rd0 !== 16'hA000 + 16'(a)) begin
                failures++;
                $display("FAIL boot_image[%0d]: got %h expected %h", a, rd0, 16'hA000 + 16'(a));
            end
            tick();
            checks++;
            if (rd1 !== m_rd1) begin
                failures++;
                $display("FAIL boot_image_reg[%0d]: got %h expected %h", a, rd1, m_rd1);
            end
        end
    endtask

    task automatic test_write();
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        for (int n = 0; n < 8; n++) begin
            a = (n == 0) ? 4'd5 : 4'($urandom_range(0, DEPTH - 1));
            d = (n == 0) ? 16'h1234 : 16'($urandom);
            we = 1'b1; wr_sel = a; wr_data = d; rd_sel = a;
            tick();
            we = 1'b0;
            #1;
            checks++;
            if (rd0 !== d) begin
                failures++;
                $display("FAIL write_comb[%h]: got %h expected %h", a, rd0, d);
            end
            tick();
            checks++;
            if (rd1 !== d) begin
                failures++;
                $display("FAIL write_reg[%h]: got %h expected %h", a, rd1, d);
            end
        end
    endtask

    task automatic test_reject();
        for (int k = 0; k < DEPTH; k++) image[k] = 16'($urandom);
        reload = 1'b1;
        tick();
        reload = 1'b0;
        checks++;
        if (ready0 !== 1'b0) begin
            failures++;
            $display("FAIL reload_drop: got %b expected 0", ready0);
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (i == 3) begin
                we = 1'b1; wr_sel = 4'($urandom); wr_data = 16'($urandom);
            end
            if (i == 5) reload = 1'b1;
            tick();
            we = 1'b0; reload = 1'b0;
            checks++;
            if (rej0 !== m_rej || rej1 !== m_rej) begin
                failures++;
                $display("FAIL reject_cycle%0d: got %b/%b expected %b", i, rej0, rej1, m_rej);
            end
            checks++;
            if (boot_addr0 !== 4'(m_cnt) || ready0 !== m_ready) begin
                failures++;
                $display("FAIL reject_boot%0d: addr=%h ready=%b expected %h/%b", i, boot_addr0, ready0, 4'(m_cnt), m_ready);
            end
        end
        for (int a = 0; a < DEPTH; a++) begin
            rd_sel = 4'(a);
            #1;
            checks++;
            if (rd0 !== image[a]) begin
                failures++;
                $display("FAIL reject_image[%0d]: got %h expected %h", a, rd0, image[a]);
            end
        end
    endtask

    task automatic test_reload_write();
        for (int k = 0; k < DEPTH; k++) image[k] = 16'hA000 + 16'(k);
        we = 1'b1; wr_sel = 4'd2; wr_data = 16'hBEEF; reload = 1'b1; rd_sel = 4'd2;
        tick();
        idle_inputs();
        #1;
        checks++;
        if (ready0 !== 1'b0 || rd0 !== 16'hBEEF) begin
            failures++;
            $display("FAIL reload_write: ready=%b rd=%h expected 0/beef", ready0, rd0);
        end
        for (int i = 0; i < DEPTH; i++) tick();
        checks++;
        if (ready0 !== 1'b1 || rd0 !== 16'hA002) begin
            failures++;
            $display("FAIL reload_reboot: ready=%b rd=%h expected 1/a002", ready0, rd0);
        end
    endtask

    task automatic test_reset_midboot();
        reload = 1'b1;
        tick();
        reload = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        rd_sel = 4'd1;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (ready0 !== 1'b0 || rd0 !== 16'h0000 || rd1 !== 16'h0000) begin
            failures++;
            $display("FAIL midboot_reset: ready=%b rd=%h/%h expected 0/0000/0000", ready0, rd0, rd1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < DEPTH - 1; i++) tick();
        checks++;
        if (ready0 !== 1'b0) begin
            failures++;
            $display("FAIL midboot_early_ready: got %b expected 0", ready0);
        end
        tick();
        checks++;
        if (ready0 !== 1'b1 || ready1 !== 1'b1) begin
            failures++;
            $display("FAIL midboot_ready: got %b/%b expected 1", ready0, ready1);
        end
        for (int a = 0; a < DEPTH; a++) begin
            rd_sel = 4'(a);
            #1;
            checks++;
            if (rd0 !== m_mem[a]) begin
                failures++;
                $display("FAIL midboot_image[%0d]: got %h expected %h", a, rd0, m_mem[a]);
            end
        end
    endtask

    task automatic test_same_addr();
        we = 1'b1; wr_sel = 4'd9; wr_data = 16'h0009;
        tick();
        rd_sel = 4'd9; wr_data = 16'hFFFF;
        #1;
        checks++;
        if (rd0 !== 16'h0009) begin
            failures++;
            $display("FAIL same_addr_old: got %h expected 0009", rd0);
        end
        tick();
        we = 1'b0;
        checks++;
        if (rd1 !== 16'h0009) begin
            failures++;
            $display("FAIL same_addr_reg_old: got %h expected 0009", rd1);
        end
        checks++;
        if (rd0 !== 16'hFFFF) begin
            failures++;
            $display("FAIL same_addr_new: got %h expected ffff", rd0);
        end
        tick();
        checks++;
        if (rd1 !== 16'hFFFF) begin
            failures++;
            $display("FAIL same_addr_reg_new: got %h expected ffff", rd1);
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < DEPTH; k++) image[k] = 16'($urandom);
        for (int n = 0; n < 60; n++) begin
            we      = 1'($urandom_range(0, 1));
            wr_sel  = 4'($urandom);
            wr_data = 16'($urandom);
            rd_sel  = 4'($urandom);
            reload  = ($urandom_range(0, 15) == 0);
            #1;
            checks++;
            if (rd0 !== m_mem[rd_sel]) begin
                failures++;
                $display("FAIL rand_comb%0d: got %h expected %h", n, rd0, m_mem[rd_sel]);
            end
            tick();
            checks++;
            if (ready0 !== m_ready || ready1 !== m_ready || rej0 !== m_rej || rej1 !== m_rej) begin
                failures++;
                $display("FAIL rand_status%0d: ready=%b/%b rej=%b/%b expected %b/%b", n, ready0, ready1, rej0, rej1, m_ready, m_rej);
            end
            checks++;
            if (rd1 !== m_rd1 || boot_addr0 !== 4'(m_cnt)) begin
                failures++;
                $display("FAIL rand_reg%0d: rd=%h addr=%h expected %h/%h", n, rd1, boot_addr0, m_rd1, 4'(m_cnt));
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_boot();
        test_write();
        test_reject();
        test_reload_write();
        test_reset_midboot();
        test_same_addr();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
